// File: rtl/hilo_muldiv_unit_if.sv
// Bundle between the decoder/datapath and the HI/LO unit: request strobes,
// operand values, read data, architectural registers and hazard signals.
interface hilo_muldiv_unit_if;
    logic        mult;
    logic        multu;
    logic        mthi;
    logic        mtlo;
    logic        mfhi;
    logic        mflo;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    modport master (
        output mult, multu, mthi, mtlo, mfhi, mflo, rs_val, rt_val,
        input  rd_data, hi, lo, busy, stall
    );

    modport slave (
        input  mult, multu, mthi, mtlo, mfhi, mflo, rs_val, rt_val,
        output rd_data, hi, lo, busy, stall
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register unit: iterative shift-add 32x32 multiplier (one multiplier bit
// per cycle) plus MTHI/MTLO/MFHI/MFLO access, stalling requests while busy.
module hilo_muldiv_unit #(
    parameter int ITER = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hilo_muldiv_unit_if.slave   bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_reg, state_next;
    logic [63:0]     acc_reg, acc_next;
    logic [31:0]     mcand_reg, mcand_next;
    logic [31:0]     mplier_reg, mplier_next;
    logic [CW-1:0]   count_reg, count_next;
    logic            neg_reg, neg_next;
    logic [31:0]     hi_reg, hi_next;
    logic [31:0]     lo_reg, lo_next;

    logic            req_any;
    logic [63:0]     partial;
    logic [63:0]     sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            count_reg  <= count_next;
            neg_reg    <= neg_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    // Signed multiplies run on magnitudes; the sign is reapplied on the last edge.
    always_comb begin
        state_next  = state_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        count_next  = count_reg;
        neg_next    = neg_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        partial = mplier_reg[count_reg] ? ({32'd0, mcand_reg} << count_reg) : 64'd0;
        sum     = acc_reg + partial;

        unique case (state_reg)
            IDLE: begin
                if (bus.mult) begin
                    mcand_next  = bus.rs_val[31] ? (32'd0 - bus.rs_val) : bus.rs_val;
                    mplier_next = bus.rt_val[31] ? (32'd0 - bus.rt_val) : bus.rt_val;
                    neg_next    = bus.rs_val[31] ^ bus.rt_val[31];
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = BUSY;
                end else if (bus.multu) begin
                    mcand_next  = bus.rs_val;
                    mplier_next = bus.rt_val;
                    neg_next    = 1'b0;
                    acc_next    = '0;
                    count_next  = '0;
                    state_next  = BUSY;
                end else begin
                    if (bus.mthi) hi_next = bus.rs_val;
                    if (bus.mtlo) lo_next = bus.rs_val;
                end
            end
            BUSY: begin
                acc_next   = sum;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(ITER - 1)) begin
                    {hi_next, lo_next} = neg_reg ? (64'd0 - sum) : sum;
                    state_next         = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_any     = bus.mult | bus.multu | bus.mthi | bus.mtlo | bus.mfhi | bus.mflo;
    assign bus.busy    = (state_reg == BUSY);
    assign bus.stall   = bus.busy & req_any;
    assign bus.hi      = hi_reg;
    assign bus.lo      = lo_reg;
    assign bus.rd_data = bus.mfhi ? hi_reg : (bus.mflo ? lo_reg : 32'd0);
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed + randomized bench for hilo_muldiv_unit against a plain-arithmetic
// model of the architectural HI/LO registers.
module tb_hilo_muldiv_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit #(.ITER(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic clear_strobes();
        bus.mult  = 1'b0;
        bus.multu = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.mfhi  = 1'b0;
        bus.mflo  = 1'b0;
    endtask

    // Issue one multiply, watch it run without side effects, then check HI/LO.
    task automatic mul_op(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          cyc;
        bit          held;
        p = ref_mul(sgn, a, b);
        @(negedge clk);
        bus.mult   = sgn;
        bus.multu  = !sgn;
        bus.rs_val = a;
        bus.rt_val = b;
        #1 chk({tag, "_accept_stall"}, 64'(bus.stall), 64'd0);
        @(negedge clk);
        clear_strobes();
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        #1;
        cyc  = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && cyc < 40) begin
            if (bus.hi !== m_hi || bus.lo !== m_lo) held = 1'b0;
            cyc++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd32);
        chk({tag, "_hilo_held"}, 64'(held), 64'd1);
        m_hi = p[63:32];
        m_lo = p[31:0];
        chk({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
        $display("mul %s sgn=%0d a=%h b=%h -> hi=%h lo=%h", tag, sgn, a, b, bus.hi, bus.lo);
    endtask

    initial begin
        int  cyc;
        bit  held;
        bit  sgn;
        logic [31:0] ra;
        logic [31:0] rb;

        checks = 0;
        errors = 0;
        m_hi   = '0;
        m_lo   = '0;
        clear_strobes();
        bus.rs_val = '0;
        bus.rt_val = '0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        chk("rst_rd", 64'(bus.rd_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_busy", 64'(bus.busy), 64'd0);
        $display("reset released: hi=%h lo=%h busy=%0d", bus.hi, bus.lo, bus.busy);

        // Directed multiplies, with spec constants checked on top of the model
        mul_op("multu_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("multu_max_hi_const", 64'(bus.hi), 64'h0FFFFFFFE);
        chk("multu_max_lo_const", 64'(bus.lo), 64'h000000001);
        mul_op("multu_3x4", 1'b0, 32'd3, 32'd4);
        chk("multu_3x4_lo_const", 64'(bus.lo), 64'h0C);
        mul_op("mult_m5x7", 1'b1, 32'hFFFFFFFB, 32'h00000007);
        chk("mult_m5x7_lo_const", 64'(bus.lo), 64'hFFFFFFDD);
        mul_op("mult_min2", 1'b1, 32'h80000000, 32'h80000000);
        chk("mult_min2_hi_const", 64'(bus.hi), 64'h40000000);
        mul_op("mult_0xm1", 1'b1, 32'h00000000, 32'hFFFFFFFF);

        // Randomized multiplies
        for (int i = 0; i < 8; i++) begin
            sgn = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) ra = 32'h80000000;
            mul_op("rand", sgn, ra, rb);
        end

        // Read hazard: mflo held while a multiply runs
        @(negedge clk);
        bus.mult   = 1'b1;
        bus.rs_val = 32'd6;
        bus.rt_val = 32'd7;
        @(negedge clk);
        clear_strobes();
        bus.mflo = 1'b1;
        #1;
        cyc  = 0;
        held = 1'b1;
        while (bus.stall === 1'b1 && cyc < 40) begin
            if (bus.lo !== m_lo) held = 1'b0;
            cyc++;
            @(negedge clk);
            #1;
        end
        m_hi = 32'd0;
        m_lo = 32'd42;
        chk("haz_stall_cycles", 64'(cyc), 64'd32);
        chk("haz_lo_held", 64'(held), 64'd1);
        chk("haz_rd", 64'(bus.rd_data), 64'(m_lo));
        chk("haz_stall_off", 64'(bus.stall), 64'd0);
        $display("hazard: stall cycles=%0d rd_data=%h", cyc, bus.rd_data);
        clear_strobes();

        // MTHI then MFHI, MTLO then MFLO, then both writes in one edge
        @(negedge clk);
        bus.mthi   = 1'b1;
        bus.rs_val = 32'h12345678;
        #1 chk("mthi_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        m_hi = 32'h12345678;
        clear_strobes();
        bus.mfhi = 1'b1;
        #1 chk("mfhi_rd", 64'(bus.rd_data), 64'(m_hi));
        chk("mfhi_stall", 64'(bus.stall), 64'd0);
        $display("mthi/mfhi: rd_data=%h", bus.rd_data);
        @(negedge clk);
        clear_strobes();
        bus.mtlo   = 1'b1;
        bus.rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        m_lo = 32'h9ABCDEF0;
        clear_strobes();
        bus.mflo = 1'b1;
        bus.mfhi = 1'b1;
        #1 chk("mfhi_prio_rd", 64'(bus.rd_data), 64'(m_hi));
        bus.mfhi = 1'b0;
        #1 chk("mflo_rd", 64'(bus.rd_data), 64'(m_lo));
        $display("mtlo/mflo: rd_data=%h", bus.rd_data);
        @(negedge clk);
        clear_strobes();
        bus.mthi   = 1'b1;
        bus.mtlo   = 1'b1;
        bus.rs_val = 32'h55AA33CC;
        @(negedge clk);
        m_hi = 32'h55AA33CC;
        m_lo = 32'h55AA33CC;
        clear_strobes();
        #1 chk("mt_both_hi", 64'(bus.hi), 64'(m_hi));
        chk("mt_both_lo", 64'(bus.lo), 64'(m_lo));

        // MTLO during BUSY: stalled, then overrides the multiply's LO
        @(negedge clk);
        bus.multu  = 1'b1;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd5;
        @(negedge clk);
        clear_strobes();
        bus.mtlo   = 1'b1;
        bus.rs_val = 32'hCAFEF00D;
        #1;
        cyc  = 0;
        held = 1'b1;
        while (bus.busy === 1'b1 && cyc < 40) begin
            if (bus.stall !== 1'b1 || bus.lo !== m_lo || bus.hi !== m_hi) held = 1'b0;
            cyc++;
            @(negedge clk);
            #1;
        end
        m_hi = 32'd0;
        m_lo = 32'd25;
        chk("mtlo_busy_cycles", 64'(cyc), 64'd32);
        chk("mtlo_busy_held", 64'(held), 64'd1);
        chk("mtlo_mul_lo", 64'(bus.lo), 64'(m_lo));
        chk("mtlo_idle_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        clear_strobes();
        m_lo = 32'hCAFEF00D;
        #1 chk("mtlo_late_lo", 64'(bus.lo), 64'(m_lo));
        chk("mtlo_late_hi", 64'(bus.hi), 64'(m_hi));
        $display("mtlo during busy: lo=%h hi=%h", bus.lo, bus.hi);

        // Reset mid-multiply discards the result and clears HI/LO
        @(negedge clk);
        bus.mult   = 1'b1;
        bus.rs_val = 32'h00012345;
        bus.rt_val = 32'hFFFF0001;
        @(negedge clk);
        clear_strobes();
        repeat (9) @(negedge clk);
        #1 chk("mid_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_hi", 64'(bus.hi), 64'(m_hi));
        chk("mid_rst_lo", 64'(bus.lo), 64'(m_lo));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.mfhi = 1'b1;
        #1 chk("after_rst_rd", 64'(bus.rd_data), 64'd0);
        chk("after_rst_stall", 64'(bus.stall), 64'd0);
        repeat (40) @(negedge clk);
        #1 chk("after_rst_lo", 64'(bus.lo), 64'(m_lo));
        $display("reset mid-multiply: busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        clear_strobes();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
